// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: response-owner
// encodings and the core start address.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_D    = 2'd2
    } rsp_t;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_dmem_arbiter_stall_counter.sv
// Enabled wrap-around event counter with asynchronous active-high reset,
// used for the fetch and data stall statistics.
module stall_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one synchronous-read single-port RAM between instruction fetch
// and the data stage, returning each response to its owner one cycle later.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    input  logic             if_flush,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             d_req,
    input  logic [3:0]       d_wen,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wen,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] if_stall_cnt,
    output logic [CNT_W-1:0] d_stall_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    rsp_t       rsp;
    rsp_t       rsp_next;
    logic [3:0] starve_cnt;
    logic       if_ok;
    logic       if_prio;
    logic       if_win;
    logic       d_win;
    logic       if_stall_en;
    logic       d_stall_en;

    // Data normally wins; a fetch refused STARVE_MAX times takes priority.
    always_comb begin
        if_ok   = if_req & ~if_flush;
        if_prio = if_ok & (starve_cnt == STARVE_LIM);
        if_win  = if_prio | (if_ok & ~d_req);
        d_win   = d_req & ~if_prio;
    end

    always_comb begin
        if_gnt    = if_win & ~reset;
        d_gnt     = d_win & ~reset;
        mem_addr  = d_win ? d_addr : if_addr;
        mem_wdata = d_win ? d_wdata : '0;
        mem_wen   = d_gnt ? d_wen : '0;
    end

    // Flush cycles neither count toward nor clear starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (if_gnt || !if_req)
            starve_cnt <= '0;
        else if (!if_flush && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rsp <= R_NONE;
        else
            rsp <= rsp_next;
    end

    always_comb begin
        rsp_next = R_NONE;
        if (if_gnt)
            rsp_next = R_IF;
        else if (d_gnt)
            rsp_next = R_D;
    end

    always_comb begin
        if_rvalid = (rsp == R_IF) & ~if_flush & ~reset;
        d_rvalid  = (rsp == R_D) & ~reset;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

    always_comb begin
        if_stall_en = if_req & ~if_gnt;
        d_stall_en  = d_req & ~d_gnt;
    end

    stall_counter #(.CNT_W(CNT_W)) u_if_stall (
        .clk   (clk),
        .reset (reset),
        .en    (if_stall_en),
        .count (if_stall_cnt)
    );

    stall_counter #(.CNT_W(CNT_W)) u_d_stall (
        .clk   (clk),
        .reset (reset),
        .en    (d_stall_en),
        .count (d_stall_cnt)
    );

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus random
// traffic against a transaction-level model with its own shadow memory.
module tb_imem_dmem_arbiter;

    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned CNT_W      = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_flush;
    logic             if_gnt;
    logic             if_rvalid;
    logic [31:0]      if_rdata;
    logic             d_req;
    logic [3:0]       d_wen;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [31:0]      d_rdata;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_wen;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] if_stall_cnt;
    logic [CNT_W-1:0] d_stall_cnt;

    imem_dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_wen        (d_wen),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .if_stall_cnt (if_stall_cnt),
        .d_stall_cnt  (d_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] init_word(int unsigned i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Unified RAM seen by the arbiter: byte writes, one-cycle read of old data.
    logic [31:0] tbmem [0:1023];
    logic        tb_init;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) tbmem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) tbmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= tbmem[mem_addr[11:2]];
    end

    // Reference model state: who owns next cycle's response, its data,
    // refusals in a row, and the stall statistics.
    int               m_starve;
    int               m_pend;
    logic [31:0]      m_rdata;
    logic [31:0]      m_mem [0:1023];
    logic [CNT_W-1:0] m_if_stall;
    logic [CNT_W-1:0] m_d_stall;

    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [71:0] exp_ctl;
    logic [71:0] got_ctl;

    assign got_ctl = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wen, if_stall_cnt, d_stall_cnt};

    task automatic model_clear;
        m_starve   = 0;
        m_pend     = 0;
        m_rdata    = '0;
        m_if_stall = '0;
        m_d_stall  = '0;
    endtask

    task automatic model_eval;
        logic fetch_ok, fetch_first;
        fetch_ok    = if_req && !if_flush;
        fetch_first = fetch_ok && (m_starve == STARVE_MAX);
        e_if_gnt    = fetch_first || (fetch_ok && !d_req);
        e_d_gnt     = d_req && !fetch_first;
        e_wen       = e_d_gnt ? d_wen : 4'h0;
        e_addr      = e_d_gnt ? d_addr : if_addr;
        e_if_rv     = (m_pend == 1) && !if_flush;
        e_d_rv      = (m_pend == 2);
        exp_ctl     = {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_wen, m_if_stall, m_d_stall};
    endtask

    task automatic model_commit;
        if (if_req && !e_if_gnt) m_if_stall = m_if_stall + 1;
        if (d_req && !e_d_gnt)   m_d_stall  = m_d_stall + 1;
        if (e_if_gnt || !if_req)
            m_starve = 0;
        else if (!if_flush && m_starve < STARVE_MAX)
            m_starve = m_starve + 1;
        m_pend  = e_if_gnt ? 1 : (e_d_gnt ? 2 : 0);
        m_rdata = m_mem[e_addr[11:2]];
        if (e_d_gnt)
            for (int b = 0; b < 4; b++)
                if (d_wen[b]) m_mem[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd);
        if_req   = ir;
        if_addr  = ia;
        if_flush = fl;
        d_req    = dr;
        d_wen    = dw;
        d_addr   = da;
        d_wdata  = dd;
        model_eval();
    endtask

    task automatic advance;
        @(posedge clk);
        if (reset) model_clear();
        else       model_commit();
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 32'h10, 1'b0, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wen} !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_outputs cyc %0d: got %b expected 00000000", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wen});
            end
            n_checks++;
            if ({if_stall_cnt, d_stall_cnt} !== 64'h0) begin
                n_errors++;
                $display("FAIL reset_counters: got %h/%h expected 0/0", if_stall_cnt, d_stall_cnt);
            end
        end
        @(posedge clk);
        #1;
        tb_init = 1'b0;
        reset   = 1'b0;
        model_clear();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_fetch_only;
        logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'h0};
        for (int c = 0; c < 4; c++) begin
            drive(c < 3, addrs[c], 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_errors++;
                $display("FAIL fetch_ctl cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            n_checks++;
            if ((e_if_gnt && mem_addr !== e_addr) || (e_if_rv && if_rdata !== m_rdata)) begin
                n_errors++;
                $display("FAIL fetch_data cyc %0d: got addr %h rdata %h expected addr %h rdata %h",
                         c, mem_addr, if_rdata, e_addr, m_rdata);
            end
            advance();
        end
        n_checks++;
        if (if_stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL fetch_stall_cnt: got %0d expected 0", if_stall_cnt);
        end
    endtask

    task automatic test_contention;
        logic [31:0] want;
        want = init_word(32'h100 >> 2);
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, 32'hC, 1'b0, c == 0, 4'h0, 32'h100, 32'h0);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_errors++;
                $display("FAIL contention_ctl cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            n_checks++;
            if (((e_if_gnt || e_d_gnt) && mem_addr !== e_addr) || (e_if_rv && if_rdata !== m_rdata)
                || (e_d_rv && d_rdata !== m_rdata)) begin
                n_errors++;
                $display("FAIL contention_data cyc %0d: got addr %h rdata %h expected addr %h rdata %h",
                         c, mem_addr, d_rdata, e_addr, m_rdata);
            end
            if (c == 1) begin
                n_checks++;
                if (d_rdata !== want) begin
                    n_errors++;
                    $display("FAIL contention_load: got %h expected %h", d_rdata, want);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (if_stall_cnt !== 32'd1) begin
                    n_errors++;
                    $display("FAIL contention_stall_cnt: got %0d expected 1", if_stall_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_starvation;
        logic [5:0] if_seq, d_seq;
        for (int c = 0; c < 7; c++) begin
            drive(c < 6, 32'h10, 1'b0, c < 6, 4'h0, 32'h104, 32'h0);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_errors++;
                $display("FAIL starve_ctl cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            if (c < 6) begin
                if_seq[c] = if_gnt;
                d_seq[c]  = d_gnt;
            end else begin
                n_checks++;
                if ({if_seq, d_seq} !== {6'b001000, 6'b110111}) begin
                    n_errors++;
                    $display("FAIL starve_pattern: got if %b d %b expected if 001000 d 110111",
                             if_seq, d_seq);
                end
                n_checks++;
                if (d_stall_cnt !== 32'd1) begin
                    n_errors++;
                    $display("FAIL starve_d_stall_cnt: got %0d expected 1", d_stall_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_store;
        logic [31:0] orig, want;
        orig = init_word(32'h200 >> 2);
        want = {orig[31:16], 16'hCCDD};
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b0, (c == 0) || (c == 2), (c == 0) ? 4'b0011 : 4'b0000,
                  32'h200, 32'hAABB_CCDD);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_errors++;
                $display("FAIL store_ctl cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            n_checks++;
            if ((e_d_gnt && (mem_addr !== e_addr || mem_wdata !== d_wdata))
                || (e_d_rv && d_rdata !== m_rdata)) begin
                n_errors++;
                $display("FAIL store_data cyc %0d: got addr %h wdata %h rdata %h expected addr %h wdata %h rdata %h",
                         c, mem_addr, mem_wdata, d_rdata, e_addr, d_wdata, m_rdata);
            end
            if (c == 3) begin
                n_checks++;
                if (d_rdata !== want) begin
                    n_errors++;
                    $display("FAIL store_readback: got %h expected %h", d_rdata, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush;
        logic [31:0] addrs [4] = '{32'h40, 32'h44, 32'h44, 32'h0};
        for (int c = 0; c < 4; c++) begin
            drive(c < 3, addrs[c], c == 1, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_errors++;
                $display("FAIL flush_ctl cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            n_checks++;
            if ((e_if_gnt && mem_addr !== e_addr) || (e_if_rv && if_rdata !== m_rdata)) begin
                n_errors++;
                $display("FAIL flush_data cyc %0d: got addr %h rdata %h expected addr %h rdata %h",
                         c, mem_addr, if_rdata, e_addr, m_rdata);
            end
            if (c == 1 || c == 3) begin
                n_checks++;
                if ({if_gnt, if_rvalid} !== ((c == 1) ? 2'b00 : 2'b01)) begin
                    n_errors++;
                    $display("FAIL flush_handshake cyc %0d: got gnt/rvalid %b expected %b", c,
                             {if_gnt, if_rvalid}, (c == 1) ? 2'b00 : 2'b01);
                end
            end
            advance();
        end
    endtask

    task automatic test_random;
        logic        ir = 1'b0, dr = 1'b0, fl;
        logic [31:0] ia = '0, da = '0, dd = '0;
        logic [3:0]  dw = '0;
        for (int c = 0; c < 400; c++) begin
            if (!ir || e_if_gnt) begin
                ir = ($urandom_range(0, 99) < 60);
                ia = 32'($urandom_range(0, 255)) << 2;
            end
            if (!dr || e_d_gnt) begin
                dr = ($urandom_range(0, 99) < 55);
                da = 32'($urandom_range(0, 255)) << 2;
                dd = $urandom;
                dw = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(ir, ia, fl, dr, dw, da, dd);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_errors++;
                $display("FAIL random_ctl cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            n_checks++;
            if (((e_if_gnt || e_d_gnt) && mem_addr !== e_addr) || (e_d_gnt && mem_wdata !== d_wdata)
                || (e_if_rv && if_rdata !== m_rdata) || (e_d_rv && d_rdata !== m_rdata)) begin
                n_errors++;
                $display("FAIL random_data cyc %0d: got addr %h wdata %h rdata %h expected addr %h wdata %h rdata %h",
                         c, mem_addr, mem_wdata, mem_rdata, e_addr, d_wdata, m_rdata);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_access;
        drive(1'b0, 32'h30, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        n_checks++;
        if (got_ctl !== exp_ctl) begin
            n_errors++;
            $display("FAIL rstmid_grant: got %h expected %h", got_ctl, exp_ctl);
        end
        #1;
        reset  = 1'b1;
        if_req = 1'b1;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            else       #1;
            n_checks++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wen} !== 8'h00) begin
                n_errors++;
                $display("FAIL rstmid_outputs cyc %0d: got %b expected 00000000", c,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wen});
            end
            n_checks++;
            if ({if_stall_cnt, d_stall_cnt} !== 64'h0) begin
                n_errors++;
                $display("FAIL rstmid_counters cyc %0d: got %h/%h expected 0/0", c,
                         if_stall_cnt, d_stall_cnt);
            end
            if (c > 0) advance();
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (got_ctl !== exp_ctl || d_rvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL rstmid_after cyc %0d: got %h expected %h", c, got_ctl, exp_ctl);
            end
            advance();
        end
    endtask

    initial begin
        reset   = 1'b1;
        tb_init = 1'b1;
        for (int i = 0; i < 1024; i++) m_mem[i] = init_word(i);
        model_clear();
        e_if_gnt = 1'b0;
        e_d_gnt  = 1'b0;
        test_reset();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_store();
        test_flush();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
